processor_loader: RTL and testbench

Front-end sequencer that sits directly upstream of the single-cycle MIPS core. It accepts a word stream of header, program and data over a valid/ready input, and writes the words into the core's instruction and data memories while holding the core in reset. It then releases the core, waits for `proc_done` under a timeout, and streams a window of data memory back out over a valid/ready output.

---
 rtl/processor_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_processor_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_loader.sv
// Loader/sequencer in front of the single-cycle MIPS core: loads program and data
// memories from a word stream, runs the core under a timeout, then drains results.
module processor_loader #(
    parameter int RESULT_BASE = 0,
    parameter int TIMEOUT     = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [9:0]  instr_addr,
    output logic        ins_we,
    output logic [31:0] data,
    output logic [9:0]  data_addr,
    output logic        data_we,
    output logic        proc_rst,
    input  logic [31:0] proc_out,
    input  logic        proc_done,
    output logic        busy,
    output logic        error
);

    localparam logic [9:0]  BASE_ADDR    = 10'(RESULT_BASE);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [10:0] MAX_COUNT    = 11'd1024;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_D,
        S_HDR_R,
        S_LOAD_I,
        S_LOAD_D,
        S_FLUSH,
        S_RUN,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] n_i_reg, n_i_next;
    logic [10:0] n_d_reg, n_d_next;
    logic [10:0] n_r_reg, n_r_next;
    logic [10:0] cnt_reg, cnt_next;
    logic [31:0] timer_reg, timer_next;
    logic [31:0] instr_reg, instr_next;
    logic [9:0]  instr_addr_reg, instr_addr_next;
    logic        ins_we_reg, ins_we_next;
    logic [31:0] data_reg, data_next;
    logic [9:0]  data_addr_reg, data_addr_next;
    logic        data_we_reg, data_we_next;
    logic [31:0] out_data_reg, out_data_next;
    logic        out_valid_reg, out_valid_next;

    logic [10:0] hdr_word;
    logic        hdr_zero;
    logic        hdr_big;
    logic        load_phase;
    logic        beat;

    assign hdr_word   = in_data[10:0];
    assign hdr_zero   = (hdr_word == 11'd0);
    assign hdr_big    = (hdr_word > MAX_COUNT);
    assign load_phase = (state_reg == S_IDLE)   || (state_reg == S_HDR_D) ||
                        (state_reg == S_HDR_R)  || (state_reg == S_LOAD_I) ||
                        (state_reg == S_LOAD_D);
    // Gating with rst keeps a beat from being consumed in the cycle the reset lands.
    assign in_ready   = load_phase && !rst;
    assign beat       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            n_i_reg        <= '0;
            n_d_reg        <= '0;
            n_r_reg        <= '0;
            cnt_reg        <= '0;
            timer_reg      <= '0;
            instr_reg      <= '0;
            instr_addr_reg <= '0;
            ins_we_reg     <= 1'b0;
            data_reg       <= '0;
            data_addr_reg  <= '0;
            data_we_reg    <= 1'b0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            n_i_reg        <= n_i_next;
            n_d_reg        <= n_d_next;
            n_r_reg        <= n_r_next;
            cnt_reg        <= cnt_next;
            timer_reg      <= timer_next;
            instr_reg      <= instr_next;
            instr_addr_reg <= instr_addr_next;
            ins_we_reg     <= ins_we_next;
            data_reg       <= data_next;
            data_addr_reg  <= data_addr_next;
            data_we_reg    <= data_we_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        n_i_next        = n_i_reg;
        n_d_next        = n_d_reg;
        n_r_next        = n_r_reg;
        cnt_next        = cnt_reg;
        timer_next      = timer_reg;
        instr_next      = instr_reg;
        instr_addr_next = instr_addr_reg;
        ins_we_next     = 1'b0;
        data_next       = data_reg;
        data_addr_next  = data_addr_reg;
        data_we_next    = 1'b0;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (beat) begin
                    if (hdr_zero || hdr_big) begin
                        state_next = S_ERR;
                    end else begin
                        n_i_next   = hdr_word;
                        state_next = S_HDR_D;
                    end
                end
            end
            S_HDR_D: begin
                if (beat) begin
                    if (hdr_big) begin
                        state_next = S_ERR;
                    end else begin
                        n_d_next   = hdr_word;
                        state_next = S_HDR_R;
                    end
                end
            end
            S_HDR_R: begin
                if (beat) begin
                    if (hdr_zero || hdr_big) begin
                        state_next = S_ERR;
                    end else begin
                        n_r_next   = hdr_word;
                        cnt_next   = '0;
                        state_next = S_LOAD_I;
                    end
                end
            end
            S_LOAD_I: begin
                if (beat) begin
                    instr_next      = in_data;
                    instr_addr_next = cnt_reg[9:0];
                    ins_we_next     = 1'b1;
                    if (cnt_reg == n_i_reg - 11'd1) begin
                        cnt_next   = '0;
                        state_next = (n_d_reg == 11'd0) ? S_FLUSH : S_LOAD_D;
                    end else begin
                        cnt_next = cnt_reg + 11'd1;
                    end
                end
            end
            S_LOAD_D: begin
                if (beat) begin
                    data_next      = in_data;
                    data_addr_next = cnt_reg[9:0];
                    data_we_next   = 1'b1;
                    if (cnt_reg == n_d_reg - 11'd1) begin
                        cnt_next   = '0;
                        state_next = S_FLUSH;
                    end else begin
                        cnt_next = cnt_reg + 11'd1;
                    end
                end
            end
            S_FLUSH: begin
                // One idle cycle so the final write pulse lands while the core is still in reset.
                timer_next = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (proc_done) begin
                    cnt_next       = '0;
                    data_addr_next = BASE_ADDR;
                    out_valid_next = 1'b0;
                    state_next     = S_DRAIN;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = S_ERR;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            S_DRAIN: begin
                // Alternate capture and hold: data_addr settles first, then proc_out is sampled.
                if (!out_valid_reg) begin
                    out_data_next  = proc_out;
                    out_valid_next = 1'b1;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (cnt_reg == n_r_reg - 11'd1) begin
                        state_next = S_IDLE;
                    end else begin
                        cnt_next       = cnt_reg + 11'd1;
                        data_addr_next = data_addr_reg + 10'd1;
                    end
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign instr      = instr_reg;
    assign instr_addr = instr_addr_reg;
    assign ins_we     = ins_we_reg;
    assign data       = data_reg;
    assign data_addr  = data_addr_reg;
    assign data_we    = data_we_reg;
    assign proc_rst   = !((state_reg == S_RUN) || (state_reg == S_DRAIN));
    assign busy       = !((state_reg == S_IDLE) || (state_reg == S_ERR));
    assign error      = (state_reg == S_ERR);

endmodule

// File: tb/tb_processor_loader.sv
// Bench for processor_loader: a tiny behavioural core stands in for the MIPS core,
// a scoreboard checks memory writes and drained results.
module tb_processor_loader;

    localparam int RB = 1023;
    localparam int TO = 50;
    localparam logic [31:0] HALT  = 32'hC000_0000;
    localparam logic [31:0] JSELF = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic [9:0]  instr_addr;
    logic        ins_we;
    logic [31:0] data;
    logic [9:0]  data_addr;
    logic        data_we;
    logic        proc_rst;
    logic [31:0] proc_out;
    logic        proc_done;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    processor_loader #(.RESULT_BASE(RB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .instr_addr(instr_addr), .ins_we(ins_we),
        .data(data), .data_addr(data_addr), .data_we(data_we),
        .proc_rst(proc_rst), .proc_out(proc_out), .proc_done(proc_done),
        .busy(busy), .error(error)
    );

    // Core stand-in: op[31:30] 01 = add dst,s1,s2 (10-bit fields); 11 = halt; 10 = jump to self.
    logic [31:0] imem [0:1023] = '{default: 32'h0};
    logic [31:0] dmem [0:1023] = '{default: 32'h0};
    logic [9:0]  pc = '0;
    logic        halted = 1'b0;

    assign proc_out  = dmem[data_addr];
    assign proc_done = halted;

    always @(posedge clk) begin
        if (ins_we) imem[instr_addr] <= instr;
        if (data_we) dmem[data_addr] <= data;
        if (proc_rst) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            case (imem[pc][31:30])
                2'b01: begin
                    dmem[imem[pc][29:20]] <= dmem[imem[pc][19:10]] + dmem[imem[pc][9:0]];
                    pc <= pc + 10'd1;
                end
                2'b11: halted <= 1'b1;
                2'b10: pc <= pc;
                default: pc <= pc + 10'd1;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct packed {
        logic        kind;
        logic [9:0]  addr;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] out_q[$];
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;

    task automatic mon_step();
        wr_t e;
        wr_t o;
        if (ins_we || data_we) begin
            o.kind = data_we;
            o.addr = data_we ? data_addr : instr_addr;
            o.d    = data_we ? data : instr;
            check("we_under_proc_rst", 64'(proc_rst), 64'd1);
            if (wr_q.size() == 0) begin
                check("write_expected", 64'(wr_q.size()), 64'd1);
            end else begin
                e = wr_q.pop_front();
                check("write", 64'(o), 64'(e));
            end
        end
        if (out_valid && held_v) check("out_hold", 64'(out_data), 64'(held_d));
        if (out_valid && out_ready) begin
            if (out_q.size() == 0) check("out_expected", 64'(out_q.size()), 64'd1);
            else check("out_word", 64'(out_data), 64'(out_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        mon_step();
        held_v <= out_valid && !out_ready;
        held_d <= out_data;
    end

    int last_beat = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat transfers.
    task automatic send(input logic [31:0] w, input bit push, input wr_t e);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n == 20) check("in_ready_wait", 64'(in_ready), 64'd1);
        if (push) wr_q.push_back(e);
        last_beat = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] prog[$];

    task automatic load(input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2);
        wr_t e;
        int  ni;
        ni = int'(h0[10:0]);
        e  = '0;
        send(h0, 1'b0, e);
        send(h1, 1'b0, e);
        send(h2, 1'b0, e);
        foreach (prog[i]) begin
            e.kind = (i >= ni);
            e.addr = (i >= ni) ? 10'(i - ni) : 10'(i);
            e.d    = prog[i];
            send(prog[i], 1'b1, e);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] enc_add(input logic [9:0] d, input logic [9:0] s1, input logic [9:0] s2);
        return {2'b01, d, s1, s2};
    endfunction

    task automatic load_sum_program();
        prog = {};
        prog.push_back(enc_add(10'd1023, 10'd0, 10'd1));
        prog.push_back(enc_add(10'd2, 10'd0, 10'd1));
        prog.push_back(HALT);
        prog.push_back(32'd5);
        prog.push_back(32'd7);
        out_q.push_back(32'd12);
        out_q.push_back(32'd5);
        out_q.push_back(32'd7);
        out_q.push_back(32'd12);
        load(32'd3, 32'd2, 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int td;
        int n;
        int t;
        int xc[$];
        logic [3:0] pat;
        pat = 4'b1001;

        // Reset values
        tick();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_ins_we", 64'(ins_we), 64'd0);
        check("rst_data_we", 64'(data_we), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_instr_addr", 64'(instr_addr), 64'd0);
        check("rst_data_addr", 64'(data_addr), 64'd0);
        check("rst_proc_rst", 64'(proc_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Header N_I=0 -> ERR after word0
        send(32'd0, 1'b0, '0);
        @(negedge clk);
        check("ni0_error", 64'(error), 64'd1);
        check("ni0_in_ready", 64'(in_ready), 64'd0);
        check("ni0_proc_rst", 64'(proc_rst), 64'd1);
        check("ni0_busy", 64'(busy), 64'd0);
        do_reset();
        @(negedge clk);
        check("err_cleared", 64'(error), 64'd0);
        tick();

        // Header N_I=1025 -> ERR after word0
        send(32'd1025, 1'b0, '0);
        @(negedge clk);
        check("ni1025_error", 64'(error), 64'd1);
        do_reset();
        tick();

        // Header N_D=1025 -> ERR after word1
        send(32'd1, 1'b0, '0);
        @(negedge clk);
        check("nd_hdr0_no_error", 64'(error), 64'd0);
        check("nd_hdr0_busy", 64'(busy), 64'd1);
        tick();
        send(32'd1025, 1'b0, '0);
        @(negedge clk);
        check("nd1025_error", 64'(error), 64'd1);
        check("nd1025_in_ready", 64'(in_ready), 64'd0);
        do_reset();
        tick();

        // Reset in the middle of LOAD_I
        prog = {};
        prog.push_back(32'h1234_5678);
        load(32'd3, 32'd0, 32'd1);
        rst      = 1'b1;
        in_data  = 32'h0BAD_0BAD;
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_blocks_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_no_we", 64'(ins_we), 64'd0);
        check("post_rst_proc_rst", 64'(proc_rst), 64'd1);
        tick();

        // Full run with back-to-back load and backpressured drain (wraps 1023 -> 0)
        load_sum_program();
        t = last_beat;
        @(negedge clk);
        check("flush_cycle", 64'(cyc - t), 64'd1);
        check("flush_data_we", 64'(data_we), 64'd1);
        check("flush_proc_rst", 64'(proc_rst), 64'd1);
        @(negedge clk);
        check("run_proc_rst_low", 64'(proc_rst), 64'd0);
        check("run_busy", 64'(busy), 64'd1);
        n = 0;
        while (!proc_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("proc_done_seen", 64'(proc_done), 64'd1);
        td = cyc;
        @(negedge clk);
        check("drain_capture_no_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("first_valid_latency", 64'(cyc - td), 64'd2);
        check("first_out_valid", 64'(out_valid), 64'd1);
        check("first_out_data", 64'(out_data), 64'd12);
        for (int i = 0; i < 60 && busy; i++) begin
            @(posedge clk);
            #1;
            out_ready = pat[i % 4];
            @(negedge clk);
        end
        check("drain_done_busy", 64'(busy), 64'd0);
        check("drain_done_proc_rst", 64'(proc_rst), 64'd1);
        check("drain_done_out_valid", 64'(out_valid), 64'd0);
        check("out_q_drained", 64'(out_q.size()), 64'd0);
        tick();

        // Second run, sink always ready: one word every 2 cycles
        out_ready = 1'b1;
        load_sum_program();
        n = 0;
        while (!proc_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("proc_done_seen2", 64'(proc_done), 64'd1);
        td = cyc;
        xc = {};
        for (int i = 0; i < 40 && busy; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) xc.push_back(cyc);
        end
        check("xfer_count", 64'(xc.size()), 64'd4);
        if (xc.size() > 0) check("xfer_first_latency", 64'(xc[0] - td), 64'd2);
        for (int i = 1; i < xc.size(); i++) check("xfer_gap", 64'(xc[i] - xc[i-1]), 64'd2);
        check("out_q_drained2", 64'(out_q.size()), 64'd0);
        out_ready = 1'b0;
        tick();

        // Jump-to-self program: timeout exactly TO cycles after entering RUN
        prog = {};
        prog.push_back(JSELF);
        load(32'd1, 32'd0, 32'd1);
        t = last_beat;
        while (cyc < t + 2 + TO - 1) @(negedge clk);
        check("timeout_not_yet_error", 64'(error), 64'd0);
        check("timeout_not_yet_proc_rst", 64'(proc_rst), 64'd0);
        @(negedge clk);
        check("timeout_error", 64'(error), 64'd1);
        check("timeout_proc_rst", 64'(proc_rst), 64'd1);
        check("timeout_in_ready", 64'(in_ready), 64'd0);
        check("timeout_out_valid", 64'(out_valid), 64'd0);
        do_reset();
        @(negedge clk);
        check("timeout_cleared", 64'(error), 64'd0);

        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
